id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a five-stage RISC-V style integer pipeline,
// together with the operand bypass network and hazard detection for the
// instruction sitting in EX.
//
// Build option:
//   ID_EX_FORWARDING_EN  defined   -> operands bypassed from MEM (preferred)
//                                     and WB; stall only on a load-use hazard.
//                        undefined -> no bypassing (ForwardA/ForwardB = 00);
//                                     stall on any RAW dependency of the
//                                     decode sources against EX or MEM.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   stall_in, flush_in   hold the register / load a bubble (flush wins)
//   *_D                  decoded instruction fields captured into EX
//   ALUResult_M, rd_M, RegWrite_M   MEM-stage bypass source
//   Result_W, rd_W, RegWrite_W      WB-stage bypass source
//   a_in, b_in, ALUControl          ALU operands and operation for EX
//   valid_E, pc_E, WriteData_E, rd_E, RegWrite_E, ResultSrc_E, MemWrite_E
//                        registered EX fields handed down the pipe
//   ForwardA, ForwardB   operand source select (00 reg, 01 WB, 10 MEM)
//   stall_req            hazard request back to fetch/decode
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             flush_in,

    input  logic             valid_D,
    input  logic [WIDTH-1:0] pc_D,
    input  logic [WIDTH-1:0] rd1_D,
    input  logic [WIDTH-1:0] rd2_D,
    input  logic [WIDTH-1:0] imm_D,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_D,
    input  logic [2:0]       ALUControl_D,
    input  logic             ALUSrc_D,
    input  logic             RegWrite_D,
    input  logic [1:0]       ResultSrc_D,
    input  logic             MemWrite_D,

    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [4:0]       rd_M,
    input  logic             RegWrite_M,
    input  logic [WIDTH-1:0] Result_W,
    input  logic [4:0]       rd_W,
    input  logic             RegWrite_W,

    output logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] b_in,
    output logic [2:0]       ALUControl,

    output logic             valid_E,
    output logic [WIDTH-1:0] pc_E,
    output logic [WIDTH-1:0] WriteData_E,
    output logic [4:0]       rd_E,
    output logic             RegWrite_E,
    output logic [1:0]       ResultSrc_E,
    output logic             MemWrite_E,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             stall_req
);

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    // -------------------------------------------------------------------------
    // Pipeline register state
    // -------------------------------------------------------------------------
    logic             valid_reg,      valid_next;
    logic [WIDTH-1:0] pc_reg,         pc_next;
    logic [WIDTH-1:0] rd1_reg,        rd1_next;
    logic [WIDTH-1:0] rd2_reg,        rd2_next;
    logic [WIDTH-1:0] imm_reg,        imm_next;
    logic [4:0]       rs1_reg,        rs1_next;
    logic [4:0]       rs2_reg,        rs2_next;
    logic [4:0]       rd_reg,         rd_next;
    logic [2:0]       alu_ctrl_reg,   alu_ctrl_next;
    logic             alu_src_reg,    alu_src_next;
    logic             reg_write_reg,  reg_write_next;
    logic [1:0]       result_src_reg, result_src_next;
    logic             mem_write_reg,  mem_write_next;

    always_comb begin
        // hold by default (covers stall_in without flush_in)
        valid_next      = valid_reg;
        pc_next         = pc_reg;
        rd1_next        = rd1_reg;
        rd2_next        = rd2_reg;
        imm_next        = imm_reg;
        rs1_next        = rs1_reg;
        rs2_next        = rs2_reg;
        rd_next         = rd_reg;
        alu_ctrl_next   = alu_ctrl_reg;
        alu_src_next    = alu_src_reg;
        reg_write_next  = reg_write_reg;
        result_src_next = result_src_reg;
        mem_write_next  = mem_write_reg;

        if (flush_in) begin
            // Bubble: the whole entry is cleared so that nothing stale can
            // leak into the bypass compare or the side-effect enables.
            valid_next      = 1'b0;
            pc_next         = '0;
            rd1_next        = '0;
            rd2_next        = '0;
            imm_next        = '0;
            rs1_next        = 5'd0;
            rs2_next        = 5'd0;
            rd_next         = 5'd0;
            alu_ctrl_next   = 3'b000;
            alu_src_next    = 1'b0;
            reg_write_next  = 1'b0;
            result_src_next = 2'b00;
            mem_write_next  = 1'b0;
        end else if (!stall_in) begin
            valid_next      = valid_D;
            pc_next         = pc_D;
            rd1_next        = rd1_D;
            rd2_next        = rd2_D;
            imm_next        = imm_D;
            rs1_next        = rs1_D;
            rs2_next        = rs2_D;
            rd_next         = rd_D;
            alu_ctrl_next   = ALUControl_D;
            alu_src_next    = ALUSrc_D;
            // an invalid decode slot must never write state downstream
            reg_write_next  = RegWrite_D & valid_D;
            result_src_next = ResultSrc_D;
            mem_write_next  = MemWrite_D & valid_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            pc_reg         <= '0;
            rd1_reg        <= '0;
            rd2_reg        <= '0;
            imm_reg        <= '0;
            rs1_reg        <= 5'd0;
            rs2_reg        <= 5'd0;
            rd_reg         <= 5'd0;
            alu_ctrl_reg   <= 3'b000;
            alu_src_reg    <= 1'b0;
            reg_write_reg  <= 1'b0;
            result_src_reg <= 2'b00;
            mem_write_reg  <= 1'b0;
        end else begin
            valid_reg      <= valid_next;
            pc_reg         <= pc_next;
            rd1_reg        <= rd1_next;
            rd2_reg        <= rd2_next;
            imm_reg        <= imm_next;
            rs1_reg        <= rs1_next;
            rs2_reg        <= rs2_next;
            rd_reg         <= rd_next;
            alu_ctrl_reg   <= alu_ctrl_next;
            alu_src_reg    <= alu_src_next;
            reg_write_reg  <= reg_write_next;
            result_src_reg <= result_src_next;
            mem_write_reg  <= mem_write_next;
        end
    end

    // -------------------------------------------------------------------------
    // Operand bypass: index 0 is the rs1/a_in path, index 1 the rs2/WriteData
    // path. MEM holds the younger result, so it is checked before WB.
    // -------------------------------------------------------------------------
    logic [4:0]       rs_e    [2];
    logic [WIDTH-1:0] reg_val [2];
    logic [1:0]       fwd     [2];
    logic [WIDTH-1:0] opnd    [2];

    assign rs_e[0]    = rs1_reg;
    assign rs_e[1]    = rs2_reg;
    assign reg_val[0] = rd1_reg;
    assign reg_val[1] = rd2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
`ifdef ID_EX_FORWARDING_EN
            logic hit_m;
            logic hit_w;

            // x0 is hard-wired zero, so a "write" to it is never a producer
            assign hit_m = RegWrite_M && (rd_M != 5'd0) && (rd_M == rs_e[gi]);
            assign hit_w = RegWrite_W && (rd_W != 5'd0) && (rd_W == rs_e[gi]);

            assign fwd[gi] = !valid_reg ? FWD_REG :
                             hit_m      ? FWD_MEM :
                             hit_w      ? FWD_WB  : FWD_REG;
`else
            assign fwd[gi] = FWD_REG;
`endif
            assign opnd[gi] = (fwd[gi] == FWD_MEM) ? ALUResult_M :
                              (fwd[gi] == FWD_WB)  ? Result_W    : reg_val[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Hazard detection against the instruction currently in decode
    // -------------------------------------------------------------------------
`ifdef ID_EX_FORWARDING_EN
    // Only a load in EX cannot be bypassed in time: its data appears in MEM.
    assign stall_req = valid_reg && (result_src_reg == RES_LOAD) &&
                       (rd_reg != 5'd0) &&
                       ((rd_reg == rs1_D) || (rd_reg == rs2_D)) && valid_D;
`else
    // Without bypassing, decode must wait until every pending producer in
    // EX or MEM has retired through WB.
    logic [4:0] rs_d [2];
    logic [1:0] raw;

    assign rs_d[0] = rs1_D;
    assign rs_d[1] = rs2_D;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_raw
            assign raw[gi] = (rs_d[gi] != 5'd0) &&
                             ((reg_write_reg && valid_reg && (rd_reg == rs_d[gi])) ||
                              (RegWrite_M && (rd_M == rs_d[gi])));
        end
    endgenerate

    assign stall_req = |raw;

    // WB bypass source is irrelevant when forwarding is compiled out
    logic unused_wb_bypass;
    assign unused_wb_bypass = &{1'b0, rd_W, RegWrite_W, RES_LOAD};
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign a_in        = opnd[0];
    assign WriteData_E = opnd[1];
    assign b_in        = alu_src_reg ? imm_reg : opnd[1];
    assign ALUControl  = alu_ctrl_reg;
    assign ForwardA    = fwd[0];
    assign ForwardB    = fwd[1];

    assign valid_E     = valid_reg;
    assign pc_E        = pc_reg;
    assign rd_E        = rd_reg;
    assign RegWrite_E  = reg_write_reg;
    assign ResultSrc_E = result_src_reg;
    assign MemWrite_E  = mem_write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Scoreboard bench for id_ex_stage. A stimulus process drives one input set per
// cycle just after the rising edge, advances a behavioural model of the EX
// entry, and queues the outputs that should be visible for that cycle. A
// monitor pops and compares on every falling edge. Works in both builds
// (ID_EX_FORWARDING_EN defined or not).
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_in, flush_in;
    logic          valid_D;
    logic [W-1:0]  pc_D, rd1_D, rd2_D, imm_D;
    logic [4:0]    rs1_D, rs2_D, rd_D;
    logic [2:0]    ALUControl_D;
    logic          ALUSrc_D, RegWrite_D, MemWrite_D;
    logic [1:0]    ResultSrc_D;
    logic [W-1:0]  ALUResult_M, Result_W;
    logic [4:0]    rd_M, rd_W;
    logic          RegWrite_M, RegWrite_W;
    logic [W-1:0]  a_in, b_in, pc_E, WriteData_E;
    logic [2:0]    ALUControl;
    logic          valid_E, RegWrite_E, MemWrite_E, stall_req;
    logic [4:0]    rd_E;
    logic [1:0]    ResultSrc_E, ForwardA, ForwardB;

    id_ex_stage #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_D(valid_D), .pc_D(pc_D), .rd1_D(rd1_D), .rd2_D(rd2_D),
        .imm_D(imm_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
        .ALUControl_D(ALUControl_D), .ALUSrc_D(ALUSrc_D),
        .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D),
        .MemWrite_D(MemWrite_D),
        .ALUResult_M(ALUResult_M), .rd_M(rd_M), .RegWrite_M(RegWrite_M),
        .Result_W(Result_W), .rd_W(rd_W), .RegWrite_W(RegWrite_W),
        .a_in(a_in), .b_in(b_in), .ALUControl(ALUControl),
        .valid_E(valid_E), .pc_E(pc_E), .WriteData_E(WriteData_E),
        .rd_E(rd_E), .RegWrite_E(RegWrite_E), .ResultSrc_E(ResultSrc_E),
        .MemWrite_E(MemWrite_E), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus, model state, expectation types ----------------
    typedef struct {
        logic         reset, stall, flush, valid;
        logic [W-1:0] pc, rd1, rd2, imm;
        logic [4:0]   rs1, rs2, rd;
        logic [2:0]   alu;
        logic         alusrc, regwrite, memwrite;
        logic [1:0]   resultsrc;
        logic [W-1:0] alu_m, res_w;
        logic [4:0]   rd_m, rd_w;
        logic         rw_m, rw_w;
    } stim_t;

    typedef struct {
        logic         valid;
        logic [W-1:0] pc, rd1, rd2, imm;
        logic [4:0]   rs1, rs2, rd;
        logic [2:0]   alu;
        logic         alusrc, regwrite, memwrite;
        logic [1:0]   resultsrc;
        logic         bubble;   // entry came from a flush: data fields unspecified
    } entry_t;

    typedef struct {
        string        tag;
        logic [W-1:0] a, b, wd, pc;
        logic [1:0]   fa, fb, resultsrc;
        logic [4:0]   rd;
        logic [2:0]   alu;
        logic         valid, regwrite, memwrite, stall_req, check_data;
    } exp_t;

    exp_t   sb_q[$];
    entry_t model;
    stim_t  cur;
    int     tests = 0;
    int     fails = 0;
    int     txn   = 0;

    // ---------------- reference model ----------------
    // Which source supplies a register operand of the EX instruction.
    function automatic logic [1:0] source_of(logic [4:0] rs, entry_t e, stim_t s);
`ifdef ID_EX_FORWARDING_EN
        if (!e.valid) return 2'd0;
        if (s.rw_m && s.rd_m != 0 && s.rd_m == rs) return 2'd2;  // newest value
        if (s.rw_w && s.rd_w != 0 && s.rd_w == rs) return 2'd1;
        return 2'd0;
`else
        return 2'd0;
`endif
    endfunction

    function automatic logic [W-1:0] value_of(logic [1:0] src, logic [W-1:0] regv, stim_t s);
        if (src == 2'd2) return s.alu_m;
        if (src == 2'd1) return s.res_w;
        return regv;
    endfunction

    function automatic logic must_stall(entry_t e, stim_t s);
        logic [4:0] srcs[2];
        logic       st;
        srcs[0] = s.rs1;
        srcs[1] = s.rs2;
        st = 1'b0;
        foreach (srcs[k]) begin
`ifdef ID_EX_FORWARDING_EN
            if (s.valid && e.valid && e.resultsrc == 2'b01 && e.rd != 0 && e.rd == srcs[k])
                st = 1'b1;
`else
            if (srcs[k] != 0 && ((e.valid && e.regwrite && e.rd == srcs[k]) ||
                                 (s.rw_m && s.rd_m == srcs[k])))
                st = 1'b1;
`endif
        end
        return st;
    endfunction

    function automatic entry_t clock_edge(entry_t e, stim_t s);
        entry_t n = e;
        if (s.reset || s.flush) begin
            n = '{default: '0};
            n.bubble = s.flush && !s.reset;
        end else if (!s.stall) begin
            n.valid = s.valid;  n.pc = s.pc;   n.rd1 = s.rd1; n.rd2 = s.rd2;
            n.imm = s.imm;      n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
            n.alu = s.alu;      n.alusrc = s.alusrc;
            n.regwrite = s.regwrite & s.valid;
            n.memwrite = s.memwrite & s.valid;
            n.resultsrc = s.resultsrc;
            n.bubble = 1'b0;
        end
        return n;
    endfunction

    function automatic exp_t predict(entry_t e, stim_t s, string tag);
        exp_t x;
        x.tag = tag;
        x.fa = source_of(e.rs1, e, s);
        x.fb = source_of(e.rs2, e, s);
        x.a  = value_of(x.fa, e.rd1, s);
        x.wd = value_of(x.fb, e.rd2, s);
        x.b  = e.alusrc ? e.imm : x.wd;
        x.pc = e.pc;  x.rd = e.rd;  x.alu = e.alu;  x.valid = e.valid;
        x.regwrite = e.regwrite;  x.memwrite = e.memwrite;
        x.resultsrc = e.resultsrc;
        x.check_data = !e.bubble;
        x.stall_req = must_stall(e, s);
        return x;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.reset     = ($urandom_range(0, 59) == 0);
        s.stall     = ($urandom_range(0, 6) == 0);
        s.flush     = ($urandom_range(0, 9) == 0);
        s.valid     = ($urandom_range(0, 5) != 0);
        s.pc        = $urandom;
        s.rd1       = $urandom;
        s.rd2       = $urandom;
        s.imm       = $urandom;
        s.rs1       = 5'($urandom_range(0, 7));
        s.rs2       = 5'($urandom_range(0, 7));
        s.rd        = 5'($urandom_range(0, 7));
        s.alu       = 3'($urandom_range(0, 7));
        s.alusrc    = 1'($urandom_range(0, 1));
        s.regwrite  = 1'($urandom_range(0, 1));
        s.memwrite  = 1'($urandom_range(0, 1));
        s.resultsrc = 2'($urandom_range(0, 3));
        s.alu_m     = $urandom;
        s.res_w     = $urandom;
        s.rd_m      = 5'($urandom_range(0, 7));
        s.rd_w      = 5'($urandom_range(0, 7));
        s.rw_m      = 1'($urandom_range(0, 1));
        s.rw_w      = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic drive_pins(input stim_t s);
        reset = s.reset;   stall_in = s.stall;   flush_in = s.flush;
        valid_D = s.valid; pc_D = s.pc; rd1_D = s.rd1; rd2_D = s.rd2;
        imm_D = s.imm; rs1_D = s.rs1; rs2_D = s.rs2; rd_D = s.rd;
        ALUControl_D = s.alu; ALUSrc_D = s.alusrc; RegWrite_D = s.regwrite;
        MemWrite_D = s.memwrite; ResultSrc_D = s.resultsrc;
        ALUResult_M = s.alu_m; rd_M = s.rd_m; RegWrite_M = s.rw_m;
        Result_W = s.res_w; rd_W = s.rd_w; RegWrite_W = s.rw_w;
    endtask

    // One cycle: the edge consumes the previous inputs, then new inputs are
    // driven and the outputs expected for this cycle are queued.
    task automatic step(input stim_t s, input string tag);
        @(posedge clk);
        model = clock_edge(model, cur);
        #1;
        cur = s;
        drive_pins(s);
        if (s.reset) model = '{default: '0};  // asynchronous clear
        sb_q.push_back(predict(model, s, tag));
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string tag, input string name,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                txn++;
                chk(x.tag, "ForwardA",   32'(ForwardA),   32'(x.fa));
                chk(x.tag, "ForwardB",   32'(ForwardB),   32'(x.fb));
                chk(x.tag, "stall_req",  32'(stall_req),  32'(x.stall_req));
                chk(x.tag, "valid_E",    32'(valid_E),    32'(x.valid));
                chk(x.tag, "RegWrite_E", 32'(RegWrite_E), 32'(x.regwrite));
                chk(x.tag, "MemWrite_E", 32'(MemWrite_E), 32'(x.memwrite));
                chk(x.tag, "rd_E",       32'(rd_E),       32'(x.rd));
                chk(x.tag, "ALUControl", 32'(ALUControl), 32'(x.alu));
                if (x.check_data) begin
                    chk(x.tag, "a_in",        a_in,        x.a);
                    chk(x.tag, "b_in",        b_in,        x.b);
                    chk(x.tag, "WriteData_E", WriteData_E, x.wd);
                    chk(x.tag, "pc_E",        pc_E,        x.pc);
                    chk(x.tag, "ResultSrc_E", 32'(ResultSrc_E), 32'(x.resultsrc));
                end
                $display("[TB] txn %0d %s: valid_E=%0b a_in=%h b_in=%h fa=%0d fb=%0d stall_req=%0b",
                         txn, x.tag, valid_E, a_in, b_in, ForwardA, ForwardB, stall_req);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        stim_t s, s2;
        cur = idle();
        cur.reset = 1'b1;
        drive_pins(cur);
        model = '{default: '0};

        s = idle(); s.reset = 1'b1;
        step(s, "reset");
        step(idle(), "post_reset");

        // immediate operand, ALUControl 000
        s = idle(); s.valid = 1; s.alusrc = 1; s.imm = 32'hFFFF_FFFC;
        s.alu = 3'b000; s.rd1 = 32'h0000_0011; s.rd2 = 32'h0000_0022;
        step(s, "imm_D");
        s2 = idle(); s2.stall = 1;
        step(s2, "imm_b_in");

        // MEM beats WB on rs1 match
        s = idle(); s.valid = 1; s.rs1 = 5; s.rd1 = 32'h0000_1234;
        step(s, "fwdA_setup");
        s2 = idle(); s2.stall = 1; s2.rd_m = 5; s2.rw_m = 1; s2.alu_m = 32'h10;
        s2.rd_w = 5; s2.rw_w = 1; s2.res_w = 32'h20;
        step(s2, "fwdA_mem_over_wb");
        s2.rw_m = 0;
        step(s2, "fwdA_wb_only");

        // x0 is never bypassed
        s = idle(); s.valid = 1; s.rs2 = 0; s.rd2 = 0;
        step(s, "fwdB_x0_setup");
        s2 = idle(); s2.stall = 1; s2.rd_m = 0; s2.rw_m = 1; s2.alu_m = 32'hDEAD_BEEF;
        s2.rd_w = 0; s2.rw_w = 1; s2.res_w = 32'hCAFE_F00D;
        step(s2, "fwdB_x0");

        // load-use hazard, then hold under stall
        s = idle(); s.valid = 1; s.resultsrc = 2'b01; s.rd = 7; s.regwrite = 1;
        s.pc = 32'h100; s.rd1 = 32'hA5A5_0001;
        step(s, "load_E");
        s2 = idle(); s2.valid = 1; s2.rs1 = 3; s2.rs2 = 7; s2.stall = 1;
        s2.pc = 32'h104; s2.rd = 9; s2.regwrite = 1;
        step(s2, "load_use_stall");
        step(s2, "load_held");

        // flush and stall together: flush wins
        s = idle(); s.valid = 1; s.regwrite = 1; s.memwrite = 1; s.rd = 9; s.alu = 3'b110;
        step(s, "pre_flush");
        s2 = idle(); s2.stall = 1; s2.flush = 1;
        step(s2, "flush_pending");
        step(idle(), "flush_bubble");

        // asynchronous reset while valid_E=1, observed before the next edge
        s = idle(); s.valid = 1; s.alu = 3'b101; s.regwrite = 1; s.rd = 4;
        step(s, "pre_reset");
        s2 = idle(); s2.stall = 1;
        step(s2, "valid_before_reset");
        s2 = idle(); s2.reset = 1;
        step(s2, "async_reset");
        step(idle(), "after_reset");

        for (int i = 0; i < 300; i++) begin
            step(rand_stim(), "random");
        end

        // let the monitor drain the last expectation (bounded)
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
